decoder_scan: RTL
=================

Name: decoder_scan

Overview:
- Parametrised successor of the board's 3-to-8 LED decoder: SEL_W-bit select to OUT_W one-hot (or one-cold) LED output behind a multi-bit enable match.
- Adds a registered output and a scan mode. An internal prescaled index counter walks the lit LED up or down, or freezes it.
- Sits between board switches/buttons and the LED bank. Its index output also feeds 7-segment or debug logic.

Parameters:
- SEL_W, 3, select/index width; OUT_W = 2**SEL_W (localparam, not overridable)
- EN_W, 3, enable input width
- EN_MATCH, 3'b100, enable pattern that activates the block (EN_W bits)
- ACTIVE_LOW, 1, 1 = selected LED driven 0 and others 1; 0 = inverted polarity
- DIV, 100_000_000, clock cycles per scan step; must be >= 1; PW = max(1, $clog2(DIV))

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-low (asserted when rst==0, sampled on clk rising edge)
- enable  in  EN_W  block active only when enable==EN_MATCH
- switch  in  SEL_W  direct select value; also the scan start index
- mode  in  2  00 direct, 01 scan up, 10 scan down, 11 freeze
- led  out  OUT_W  registered decoded output
- index  out  SEL_W  registered current lit position
- step  out  1  one-cycle pulse on each scan index update

Behaviour:
- Reset (rst==0 at an edge): led = all-off (all ones if ACTIVE_LOW, else all zeros), index=0, prescaler=0, step=0, mode_q=00. Reset has priority over every other input.
- "off" pattern: all ones if ACTIVE_LOW, else all zeros. "on(i)": off pattern with bit i inverted.
- Disabled (enable != EN_MATCH):
  - led=off next cycle; step=0.
  - index, prescaler and mode_q hold, so scan resumes where it stopped on re-enable.
- Direct mode (00, enabled):
  - index<=switch; led<=on(switch); latency 1 cycle from switch to led.
  - Prescaler held at 0.
- Mode register: mode_q<=mode every enabled cycle, used for entry detection.
- Entering scan (mode in {01,10} and mode_q not in {01,10}):
  - index<=switch, prescaler<=0, led<=on(switch), step=0.
  - Switching directly between 01 and 10 is not an entry: index keeps its value, prescaler<=0.
- Scan up (01) / scan down (10), steady state:
  - Prescaler counts 0..DIV-1.
  - When prescaler==DIV-1: prescaler<=0, index<=index+1 (up) or index-1 (down), modulo 2**SEL_W (wrap 7->0 up, 0->7 down for SEL_W=3), led<=on(new index), step<=1 for that one cycle.
  - DIV=1: step every enabled cycle.
- Freeze (11): index, prescaler and led hold; step=0. Leaving freeze into scan counts as entry (reloads from switch).
- switch is ignored during scan except on entry.
- led always equals on(index) while enabled; it is never all-off while enabled.
- Mid-operation reset clears everything as above within the same edge. The first enabled cycle after reset applies current mode as an entry.
- Arithmetic: index add/sub is SEL_W bits, natural wrap. Prescaler is PW bits, with an explicit compare to DIV-1 (no reliance on overflow).

Decomposition:
- Shared package decoder_pkg: mode encoding constants MODE_DIRECT=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_FREEZE=2'b11, and an off_pattern/on_pattern function pair parameterised by OUT_W and ACTIVE_LOW.
- One sub-module: scan_prescaler (parameters DIV; inputs clk, rst, run, clear; output tick). It owns the prescaler counter and the DIV==1 corner.
- The decode, index and mode logic stay in decoder_scan.

Test Plan:
- Reset/enable: rst=0 for 2 cycles, then enable=3'b000, switch=3 -> led=8'hFF, index=0, step=0. Then enable=3'b100, mode=00 -> after 1 cycle led=8'hF7, index=3.
- Direct sweep: switch 0..7 one per cycle -> led 8'hFE, FD, FB, F7, EF, DF, BF, 7F, each 1 cycle later. enable=3'b110 mid-sweep -> led=8'hFF next cycle.
- Scan up with DIV=4: switch=6, mode 00->01 -> led=on(6) at entry; step pulses every 4 cycles; index 6->7->0->1, led 8'hBF->7F->FE->FD.
- Scan down plus direction flip (DIV=4): enter mode=10 at switch=1 -> index 1->0->7; flip to 01 at index 7 -> no reload, prescaler restarts, next step -> 0.
- Freeze and disable hold (DIV=4): freeze at index 5 for 10 cycles -> led=8'hDF, no step. Return to 01 with switch=2 -> reload to 2. Disable for 6 cycles mid-count, re-enable -> resumes from held prescaler; step count matches.
- Polarity/width: ACTIVE_LOW=0, SEL_W=4, DIV=1, mode=01 from switch=15 -> led 16'h8000 then 16'h0001 on consecutive cycles, step high every cycle. rst=0 mid-scan -> led=16'h0000, index=0 next edge.

Source files
------------

// File: rtl/decoder_scan_pkg.sv
// Shared mode encodings and LED pattern helpers for the select/scan decoder.
// Patterns are built at full helper width and truncated to OUT_W by the caller.
package decoder_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_FREEZE = 2'b11;

    // Helpers cover select widths up to 8 bits (256 LEDs).
    localparam int MAX_OUT_W = 256;

    function automatic logic [MAX_OUT_W-1:0] off_pattern(input logic active_low);
        return active_low ? {MAX_OUT_W{1'b1}} : {MAX_OUT_W{1'b0}};
    endfunction

    function automatic logic [MAX_OUT_W-1:0] on_pattern(input logic active_low,
                                                        input logic [7:0] idx);
        return off_pattern(active_low) ^ (MAX_OUT_W'(1) << idx);
    endfunction

endpackage

// File: rtl/decoder_scan_prescaler.sv
// Scan-step prescaler: tick is high combinationally on the last cycle of each DIV-cycle period.
// clear restarts the period; when run is low the count holds.
module scan_prescaler #(
    parameter int DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic          at_last;

    // With DIV==1, LAST is 0 and the counter never leaves 0, so tick tracks run.
    assign at_last = (cnt_q == LAST);
    assign tick    = run && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = at_last ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Enable-gated one-hot/one-cold LED decoder with direct, scan up/down and freeze modes.
// All outputs registered: led/index follow switch one cycle later; step pulses with each scan move.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int              SEL_W      = 3,
    parameter int              EN_W       = 3,
    parameter logic [EN_W-1:0] EN_MATCH   = EN_W'(3'b100),
    parameter bit              ACTIVE_LOW = 1'b1,
    parameter int              DIV        = 100_000_000,
    localparam int             OUT_W      = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [EN_W-1:0]  enable,
    input  logic [SEL_W-1:0] switch,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] led,
    output logic [SEL_W-1:0] index,
    output logic             step
);

    localparam logic [OUT_W-1:0] LED_OFF = OUT_W'(off_pattern(ACTIVE_LOW));

    logic [OUT_W-1:0] led_q;
    logic [SEL_W-1:0] index_q;
    logic [SEL_W-1:0] index_d;
    logic [1:0]       mode_q;
    logic             step_q;

    logic enabled;
    logic is_scan;
    logic was_scan;
    logic entry;
    logic run;
    logic clear;
    logic tick;

    assign enabled  = (enable == EN_MATCH);
    assign is_scan  = (mode == MODE_UP) || (mode == MODE_DOWN);
    assign was_scan = (mode_q == MODE_UP) || (mode_q == MODE_DOWN);
    assign entry    = is_scan && !was_scan;
    // A direction flip also restarts the period, but keeps the index.
    assign run      = enabled && is_scan && (mode == mode_q);
    assign clear    = enabled && ((mode == MODE_DIRECT) || (is_scan && (mode != mode_q)));

    scan_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .clear (clear),
        .tick  (tick)
    );

    always_comb begin
        index_d = index_q;
        if ((mode == MODE_DIRECT) || entry) begin
            index_d = switch;
        end else if (tick) begin
            index_d = (mode == MODE_UP) ? index_q + SEL_W'(1) : index_q - SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            led_q   <= LED_OFF;
            index_q <= '0;
            mode_q  <= MODE_DIRECT;
            step_q  <= 1'b0;
        end else if (!enabled) begin
            led_q  <= LED_OFF;
            step_q <= 1'b0;
        end else begin
            mode_q  <= mode;
            index_q <= index_d;
            led_q   <= OUT_W'(on_pattern(ACTIVE_LOW, 8'(index_d)));
            step_q  <= tick;
        end
    end

    assign led   = led_q;
    assign index = index_q;
    assign step  = step_q;

endmodule
